pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage; successor to the single-register PC path. Holds the fetch address and offers it to instruction fetch through a valid/ready handshake. Advances sequentially on acceptance and applies trap and branch redirects with fixed priority, inserting one flush bubble after each redirect. An optional branch target buffer supplies predicted-taken next PCs.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_btb.sv | 67 ++++++
 rtl/pc_gen.sv | 89 ++++++++
 tb/tb_pc_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pc_state_e;

   localparam int INST_BYTES = 4;

   // Widest address the BTB entry bundle can carry; narrower fields are zero-extended.
   localparam int BTB_MAX_W = 64;

   typedef struct packed {
      logic                 valid;
      logic [BTB_MAX_W-1:0] tag;
      logic [BTB_MAX_W-1:0] target;
   } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, clocked update,
// valid bits cleared by the asynchronous active-low reset.
module pc_btb
   import pc_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] i_lookup_pc,
   output logic            o_hit,
   output logic [XLEN-1:0] o_target,
   input  logic            i_upd_en,
   input  logic [XLEN-1:0] i_upd_pc,
   input  logic [XLEN-1:0] i_upd_target
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [DEPTH-1:0] r_valid;
   logic [TAG_W-1:0] r_tag    [DEPTH];
   logic [XLEN-3:0]  r_target [DEPTH];

   logic [IDX_W-1:0] w_lk_idx;
   logic [IDX_W-1:0] w_up_idx;
   btb_entry_t       w_entry;

   assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
   assign w_up_idx = i_upd_pc[IDX_W+1:2];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_valid[gi] <= 1'b0;
            end else if (i_upd_en && (w_up_idx == IDX_W'(gi))) begin
               r_valid[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   // Payload needs no reset: an entry is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (i_upd_en) begin
         r_tag[w_up_idx]    <= i_upd_pc[XLEN-1:IDX_W+2];
         r_target[w_up_idx] <= i_upd_target[XLEN-1:2];
      end
   end

   always_comb begin
      w_entry        = '0;
      w_entry.valid  = r_valid[w_lk_idx];
      w_entry.tag    = BTB_MAX_W'(r_tag[w_lk_idx]);
      w_entry.target = BTB_MAX_W'(r_target[w_lk_idx]);
   end

   assign o_hit    = w_entry.valid && (w_entry.tag == BTB_MAX_W'(i_lookup_pc[XLEN-1:IDX_W+2]));
   assign o_target = {w_entry.target[XLEN-3:0], 2'b00};

   logic w_unused_bits;
   assign w_unused_bits = ^{w_entry.target[BTB_MAX_W-1:XLEN-2], i_lookup_pc[1:0],
                            i_upd_pc[1:0], i_upd_target[1:0]};

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with valid/ready fetch handshake and trap/branch redirects.
// Optional BTB prediction is built when PC_GEN_BTB_EN is defined.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BTB_DEPTH    = 16
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   input  logic            if_ready,
   input  logic            stall,
   input  logic            trap_redirect,
   input  logic [XLEN-1:0] trap_target,
   input  logic            br_redirect,
   input  logic [XLEN-1:0] br_target,
   output logic            pred_taken,
   input  logic            btb_upd_en,
   input  logic [XLEN-1:0] btb_upd_pc,
   input  logic [XLEN-1:0] btb_upd_target
);

   pc_state_e       r_state;
   pc_state_e       w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   logic            w_xfer;
   logic            w_btb_hit;
   logic [XLEN-1:0] w_btb_target;

`ifdef PC_GEN_BTB_EN
   pc_btb #(
      .XLEN  (XLEN),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk          (clk),
      .rst          (rst),
      .i_lookup_pc  (r_pc),
      .o_hit        (w_btb_hit),
      .o_target     (w_btb_target),
      .i_upd_en     (btb_upd_en),
      .i_upd_pc     (btb_upd_pc),
      .i_upd_target (btb_upd_target)
   );
`else
   assign w_btb_hit    = 1'b0;
   assign w_btb_target = '0;

   logic w_unused_btb;
   assign w_unused_btb = ^{btb_upd_en, btb_upd_pc, btb_upd_target, (BTB_DEPTH > 1)};
`endif

   assign pc_valid   = (r_state == RUN);
   assign w_xfer     = pc_valid && if_ready;
   assign pred_taken = pc_valid && w_btb_hit;
   assign pc         = r_pc;

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      if (trap_redirect) begin
         w_pc_next    = {trap_target[XLEN-1:2], 2'b00};
         w_state_next = FLUSH;
      end else if (br_redirect) begin
         w_pc_next    = {br_target[XLEN-1:2], 2'b00};
         w_state_next = FLUSH;
      end else if (!stall) begin
         // Sequential increment wraps naturally at the XLEN boundary.
         if (w_xfer) begin
            w_pc_next = w_btb_hit ? w_btb_target : r_pc + XLEN'(INST_BYTES);
         end
         w_state_next = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= BOOT;
         r_pc    <= RESET_VECTOR;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; BTB expectations follow PC_GEN_BTB_EN.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_valid;
   logic        if_ready;
   logic        stall;
   logic        trap_redirect;
   logic [31:0] trap_target;
   logic        br_redirect;
   logic [31:0] br_target;
   logic        pred_taken;
   logic        btb_upd_en;
   logic [31:0] btb_upd_pc;
   logic [31:0] btb_upd_target;

   int n_checks = 0;
   int n_errors = 0;

`ifdef PC_GEN_BTB_EN
   localparam logic [31:0] EXP_PRED = 32'd1;
   localparam logic [31:0] EXP_NEXT = 32'h200;
`else
   localparam logic [31:0] EXP_PRED = 32'd0;
   localparam logic [31:0] EXP_NEXT = 32'h44;
`endif

   always #5 clk = ~clk;

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h100),
      .BTB_DEPTH    (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .if_ready       (if_ready),
      .stall          (stall),
      .trap_redirect  (trap_redirect),
      .trap_target    (trap_target),
      .br_redirect    (br_redirect),
      .br_target      (br_target),
      .pred_taken     (pred_taken),
      .btb_upd_en     (btb_upd_en),
      .btb_upd_pc     (btb_upd_pc),
      .btb_upd_target (btb_upd_target)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_br(input logic [31:0] tgt);
      br_redirect = 1'b1;
      br_target   = tgt;
      tick();
      br_redirect = 1'b0;
   endtask

   initial begin
      rst = 1'b0; if_ready = 1'b1; stall = 1'b0;
      trap_redirect = 1'b0; trap_target = '0;
      br_redirect = 1'b0; br_target = '0;
      btb_upd_en = 1'b0; btb_upd_pc = '0; btb_upd_target = '0;

      #12;
      check("rst_pc", pc, 32'h100);
      check("rst_valid", {31'd0, pc_valid}, 32'd0);
      check("rst_pred", {31'd0, pred_taken}, 32'd0);

      rst = 1'b1; #1;
      check("boot_valid", {31'd0, pc_valid}, 32'd0);
      tick();
      check("run_valid", {31'd0, pc_valid}, 32'd1);
      check("seq0", pc, 32'h100);
      tick();
      check("seq1", pc, 32'h104);

      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("notready_hold", pc, 32'h104);
      end
      if_ready = 1'b1; stall = 1'b1;
      tick();
      check("stall_hold", pc, 32'h104);
      check("stall_valid", {31'd0, pc_valid}, 32'd1);
      stall = 1'b0;
      tick();
      check("after_stall", pc, 32'h108);
      tick();
      check("seq2", pc, 32'h10C);

      trap_redirect = 1'b1; trap_target = 32'h800;
      br_redirect   = 1'b1; br_target   = 32'h2002;
      tick();
      trap_redirect = 1'b0; br_redirect = 1'b0;
      check("trap_pc", pc, 32'h800);
      check("trap_bubble", {31'd0, pc_valid}, 32'd0);
      tick();
      check("trap_resume", {31'd0, pc_valid}, 32'd1);
      tick();
      check("trap_seq", pc, 32'h804);

      redirect_br(32'h2002);
      check("br_align", pc, 32'h2000);
      check("br_bubble", {31'd0, pc_valid}, 32'd0);
      tick();
      check("br_resume", {31'd0, pc_valid}, 32'd1);

      br_redirect = 1'b1; br_target = 32'h3000;
      tick();
      check("b2b_first_bubble", {31'd0, pc_valid}, 32'd0);
      br_target = 32'h4000;
      tick();
      br_redirect = 1'b0;
      check("b2b_second_bubble", {31'd0, pc_valid}, 32'd0);
      check("b2b_target", pc, 32'h4000);
      tick();
      check("b2b_resume", {31'd0, pc_valid}, 32'd1);
      tick();
      check("b2b_seq", pc, 32'h4004);

      redirect_br(32'hFFFF_FFFC);
      tick();
      check("wrap_pre", pc, 32'hFFFF_FFFC);
      tick();
      check("wrap_post", pc, 32'h0);

      #2 rst = 1'b0; #1;
      check("midrst_pc", pc, 32'h100);
      check("midrst_valid", {31'd0, pc_valid}, 32'd0);
      rst = 1'b1;
      redirect_br(32'h500);
      check("boot_redir_pc", pc, 32'h500);
      check("boot_redir_flush", {31'd0, pc_valid}, 32'd0);
      tick();
      check("boot_redir_run", {31'd0, pc_valid}, 32'd1);

      btb_upd_en = 1'b1; btb_upd_pc = 32'h40; btb_upd_target = 32'h200;
      tick();
      btb_upd_en = 1'b0;
      redirect_br(32'h40);
      tick();
      check("btb_fetch_pc", pc, 32'h40);
      check("btb_pred", {31'd0, pred_taken}, EXP_PRED);
      tick();
      check("btb_next", pc, EXP_NEXT);

      #2 rst = 1'b0; #1;
      rst = 1'b1;
      redirect_br(32'h40);
      tick();
      check("btb_rst_pc", pc, 32'h40);
      check("btb_rst_pred", {31'd0, pred_taken}, 32'd0);
      tick();
      check("btb_rst_next", pc, 32'h44);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
